seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector, the next generation of the fixed three-bit "101" detector FSM. It consumes one qualified bit per cycle and compares the last PAT_W bits against a runtime-loadable pattern. It pulses `out` on every match, supports overlapping and non-overlapping match modes, and keeps a saturating match counter. It sits directly on a serial input stream, upstream of control logic that needs event flags or counts.

## Interface
- PAT_W, 3: pattern length in bits, 2..16.
- PAT_RST, 3'b101 (PAT_W bits): pattern value after reset.
- OVERLAP, 1: 1 lets matches share bits; 0 restarts the search after each match.
- CNT_W, 8: width of the match counter.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserts at 0); deassertion is synchronised externally.
- in_valid  in  1  `in` is sampled only when this is high.
- in  in  1  serial data bit.
- pat_load  in  1  loads `pat_in` as the new pattern.
- pat_in  in  PAT_W  new pattern value; bit PAT_W-1 is the oldest (first-received) bit.
- count_clear  in  1  synchronous clear of `match_count`.
- out  out  1  one-cycle match pulse.
- match_count  out  CNT_W  saturating number of matches.
- busy  out  1  high when the history holds at least one valid bit.

## Operation
- Internal state:
  - `hist`: a PAT_W-bit shift register. New bits enter at bit 0, so the oldest bit is at PAT_W-1.
  - `fill`: a counter, 0..PAT_W.
  - `pat`: the current pattern register.
  - FSM state: EMPTY, FILLING or ARMED.
- EMPTY (`fill`=0):
  - on an accepted bit, `fill` becomes 1;
  - the next state is FILLING, or ARMED if PAT_W would be reached.
- FILLING: each accepted bit shifts into `hist` and increments `fill`. The FSM moves to ARMED when `fill` reaches PAT_W.
- ARMED: each accepted bit shifts into `hist`. A match is the new `hist` value equal to `pat`.
- Match evaluation also applies on the transition into ARMED, so the first full window is checked.
- On a match:
  - `out` is 1 for exactly one cycle;
  - `match_count` increments, holding at 2^CNT_W-1.
- OVERLAP=0: a match clears `fill` to 0 and the state to EMPTY. The next match needs PAT_W fresh bits.
- OVERLAP=1: the state stays ARMED and the next bit may complete another match.
- in_valid=0: nothing changes and `out` is 0.
- pat_load=1:
  - `pat` takes `pat_in`;
  - `hist` and `fill` clear and the state goes to EMPTY;
  - any `in` bit in the same cycle is discarded and no match is reported.
- count_clear=1: `match_count` goes to 0. It has priority over a simultaneous match increment, but `out` still pulses.
- busy = (state != EMPTY).

## Timing
- Reset values:
  - `out` = 0, `match_count` = 0, `busy` = 0;
  - state EMPTY, `hist` = 0, `fill` = 0;
  - `pat` = PAT_RST.
- Reset asserted mid-stream discards the partial history immediately, without waiting for a clock.
- Latency: `out` is registered. It is high in the cycle following the edge that samples the final pattern bit, and low in the cycle after that unless another match occurs.
- `match_count` updates on the same edge that sets `out`.
- Continuous overlap example: PAT_W=3, pattern 101, OVERLAP=1, stream 1,0,1,0,1. `out` pulses after the 3rd and 5th bits.
- Saturation: at 2^CNT_W-1, further matches pulse `out` and leave the count unchanged.
- Gapped input: bits separated by in_valid=0 cycles are treated as contiguous.

## Structure
- Shared package `seq_detect_pkg` holds:
  - the state enum (EMPTY, FILLING, ARMED);
  - the PAT_W legal-range constants (min 2, max 16).
- One sub-module, `sat_counter`, parametrised by CNT_W, with inputs inc and clr and an output count. Clear has priority.
- The FSM, shift register and comparator stay in the top module.

## Test plan
- Default parameters, reset low for 2 cycles, then bits 1,0,1 with in_valid=1: `out` is 0, 0, then 1 in the cycle after the third bit; `match_count` = 1.
- OVERLAP=1, stream 1,0,1,0,1: two `out` pulses, `match_count` = 2. OVERLAP=0, same stream: one pulse, `match_count` = 1.
- PAT_W=4, pat_load with `pat_in`=4'b1100, then 1,1,0,0 with one in_valid=0 gap mid-stream: a single pulse after the 4th bit; `busy` = 1 during filling.
- pat_load asserted together with the final bit of a would-be match: no pulse, `busy` = 0 next cycle, and the new pattern matches afterwards.
- CNT_W=2, five matches: `match_count` reads 1, 2, 3, 3, 3 while `out` pulses five times. count_clear on the same cycle as a match gives `match_count` = 0 with `out` = 1.
- Reset asserted asynchronously between bits 2 and 3 of 101: all outputs 0 at once. After release, 1 then 0,1 gives exactly one match.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seq_detect_pkg;

  // Legal range of the pattern length
  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 16;

  // Detector FSM: no history, partial history, full window available
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } state_e;

endpackage : seq_detect_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Count register: clear, else increment unless already at the ceiling
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with loadable pattern, overlap mode
// and a saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned      PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(3'b101),
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             count_clear,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             busy
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  // Reject out-of-range pattern lengths at elaboration
  if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
    $error("seq_detect_param: PAT_W out of range");
  end

  state_e            state, state_d;
  logic [PAT_W-1:0]  hist, hist_d;
  logic [PAT_W-1:0]  pat, pat_d;
  logic [FILL_W-1:0] fill, fill_d;
  logic [FILL_W-1:0] fill_inc;
  logic [PAT_W-1:0]  shifted;
  logic              hit;

  assign shifted  = {hist[PAT_W-2:0], in};
  assign fill_inc = fill + FILL_W'(1);

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, history update and match detection
  always_comb begin
    state_d = state;
    hist_d  = hist;
    fill_d  = fill;
    pat_d   = pat;
    hit     = 1'b0;

    if (pat_load) begin
      // New pattern invalidates any history; a same-cycle bit is dropped
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = EMPTY;
    end else if (in_valid) begin
      hist_d = shifted;
      unique case (state)
        EMPTY, FILLING: begin
          fill_d = fill_inc;
          if (fill_inc == FILL_W'(PAT_W)) begin
            // First full window is evaluated on the way into ARMED
            state_d = ARMED;
            hit     = (shifted == pat);
          end else begin
            state_d = FILLING;
          end
        end
        ARMED: begin
          hit = (shifted == pat);
        end
        default: begin
          state_d = EMPTY;
          hist_d  = '0;
          fill_d  = '0;
        end
      endcase

      // Non-overlapping mode restarts the search from scratch
      if (hit && !OVERLAP) begin
        hist_d  = '0;
        fill_d  = '0;
        state_d = EMPTY;
      end
    end
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
      pat  <= PAT_RST;
      out  <= 1'b0;
      busy <= 1'b0;
    end else begin
      hist <= hist_d;
      fill <= fill_d;
      pat  <= pat_d;
      out  <= hit;
      busy <= (state_d != EMPTY);
    end
  end

  // Match counter
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clock (clock),
    .reset (reset),
    .inc   (hit),
    .clr   (count_clear),
    .count (match_count)
  );

endmodule : seq_detect_param

// File: tb/tb_seq_detect_param.sv
// Self-checking bench: three detector configurations driven by a shared
// stream and compared against a window-arithmetic reference model.
module tb_seq_detect_param;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in;
  logic       pat_load;
  logic       count_clear;
  logic [2:0] pat_in_a, pat_in_b;
  logic [3:0] pat_in_c;

  logic       out_a, out_b, out_c;
  logic       busy_a, busy_b, busy_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int n_checks;
  int n_fail;

  // Reference model state per instance (a: W3 overlap, b: W3 no-overlap, c: W4 cnt2)
  int unsigned m_w    [3];
  bit          m_ov   [3];
  int unsigned m_cmax [3];
  int unsigned m_rst  [3];
  int unsigned m_pat  [3];
  int unsigned m_pin  [3];
  int unsigned m_win  [3];
  int unsigned m_seen [3];
  int unsigned m_cnt  [3];
  bit          m_out  [3];

  seq_detect_param dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in(in),
    .pat_load(pat_load), .pat_in(pat_in_a), .count_clear(count_clear),
    .out(out_a), .match_count(cnt_a), .busy(busy_a)
  );

  seq_detect_param #(.OVERLAP(1'b0)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in(in),
    .pat_load(pat_load), .pat_in(pat_in_b), .count_clear(count_clear),
    .out(out_b), .match_count(cnt_b), .busy(busy_b)
  );

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1100), .CNT_W(2)) dut_c (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in(in),
    .pat_load(pat_load), .pat_in(pat_in_c), .count_clear(count_clear),
    .out(out_c), .match_count(cnt_c), .busy(busy_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_w    = '{3, 3, 4};
    m_ov   = '{1'b1, 1'b0, 1'b1};
    m_cmax = '{255, 255, 3};
    m_rst  = '{5, 5, 12};
    for (int i = 0; i < 3; i++) begin
      m_pat[i]  = m_rst[i];
      m_win[i]  = 0;
      m_seen[i] = 0;
      m_cnt[i]  = 0;
      m_out[i]  = 1'b0;
    end
  endtask

  // A match is: at least W bits accepted since the last restart, and the
  // last W of them equal the pattern.
  task automatic model_step(input bit iv, input bit b, input bit pl, input bit cc);
    for (int i = 0; i < 3; i++) begin
      bit hit;
      int unsigned mask;
      mask = (32'd1 << m_w[i]) - 1;
      hit  = 1'b0;
      if (pl) begin
        m_pat[i]  = m_pin[i] & mask;
        m_win[i]  = 0;
        m_seen[i] = 0;
      end else if (iv) begin
        m_win[i]  = ((m_win[i] << 1) | 32'(b)) & mask;
        m_seen[i] = m_seen[i] + 1;
        if (m_seen[i] >= m_w[i] && m_win[i] == m_pat[i]) begin
          hit = 1'b1;
          if (!m_ov[i]) begin
            m_seen[i] = 0;
            m_win[i]  = 0;
          end
        end
      end
      m_out[i] = hit;
      if (cc) m_cnt[i] = 0;
      else if (hit && m_cnt[i] < m_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
    end
  endtask

  task automatic check_all();
    check_eq("out_a",  32'(out_a),  32'(m_out[0]));
    check_eq("cnt_a",  32'(cnt_a),  m_cnt[0]);
    check_eq("busy_a", 32'(busy_a), 32'(m_seen[0] != 0));
    check_eq("out_b",  32'(out_b),  32'(m_out[1]));
    check_eq("cnt_b",  32'(cnt_b),  m_cnt[1]);
    check_eq("busy_b", 32'(busy_b), 32'(m_seen[1] != 0));
    check_eq("out_c",  32'(out_c),  32'(m_out[2]));
    check_eq("cnt_c",  32'(cnt_c),  m_cnt[2]);
    check_eq("busy_c", 32'(busy_c), 32'(m_seen[2] != 0));
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge
  task automatic cycle(input bit iv, input bit b, input bit pl, input bit cc);
    in_valid    = iv;
    in          = b;
    pat_load    = pl;
    count_clear = cc;
    m_pin[0] = 32'(pat_in_a);
    m_pin[1] = 32'(pat_in_b);
    m_pin[2] = 32'(pat_in_c);
    model_step(iv, b, pl, cc);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic bit_in(input bit b);
    cycle(1'b1, b, 1'b0, 1'b0);
  endtask

  initial begin
    int sat_exp[5];
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0; in_valid = 1'b0; in = 1'b0; pat_load = 1'b0; count_clear = 1'b0;
    pat_in_a = 3'b101; pat_in_b = 3'b101; pat_in_c = 4'b1100;
    model_reset();

    // Reset for two cycles
    repeat (2) @(posedge clock);
    #1;
    check_all();
    check_eq("rst_out_a", 32'(out_a), 32'd0);
    check_eq("rst_cnt_a", 32'(cnt_a), 32'd0);
    check_eq("rst_busy_a", 32'(busy_a), 32'd0);
    reset = 1'b1;

    // 1,0,1 then 0,1: overlap gives a second match, non-overlap does not
    bit_in(1'b1); check_eq("d101_out1", 32'(out_a), 32'd0);
    bit_in(1'b0); check_eq("d101_out2", 32'(out_a), 32'd0);
    bit_in(1'b1); check_eq("d101_out3", 32'(out_a), 32'd1);
    check_eq("d101_cnt", 32'(cnt_a), 32'd1);
    bit_in(1'b0);
    bit_in(1'b1);
    check_eq("ov_cnt_a", 32'(cnt_a), 32'd2);
    check_eq("nov_cnt_b", 32'(cnt_b), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Load 1100 into the 4-bit detector, stream 1,1,<gap>,0,0
    pat_in_a = 3'b101; pat_in_b = 3'b101; pat_in_c = 4'b1100;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    bit_in(1'b1); check_eq("fill_busy_c", 32'(busy_c), 32'd1);
    bit_in(1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("gap_out_c", 32'(out_c), 32'd0);
    bit_in(1'b0);
    bit_in(1'b0); check_eq("gap_match_c", 32'(out_c), 32'd1);

    // Saturation of the 2-bit counter over five matches
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    sat_exp = '{1, 2, 3, 3, 3};
    for (int k = 0; k < 5; k++) begin
      bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b0);
      check_eq("sat_out_c", 32'(out_c), 32'd1);
      check_eq("sat_cnt_c", 32'(cnt_c), 32'(sat_exp[k]));
    end

    // Clear together with a match: count 0, pulse still seen
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("clr_out_c", 32'(out_c), 32'd1);
    check_eq("clr_cnt_c", 32'(cnt_c), 32'd0);

    // pat_load on the final bit of a would-be 101 match
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    bit_in(1'b1); bit_in(1'b0);
    pat_in_a = 3'b110; pat_in_b = 3'b110;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("load_out_a", 32'(out_a), 32'd0);
    check_eq("load_busy_a", 32'(busy_a), 32'd0);
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
    check_eq("newpat_out_a", 32'(out_a), 32'd1);

    // Restore 101 and check asynchronous reset between bits 2 and 3
    pat_in_a = 3'b101; pat_in_b = 3'b101;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    bit_in(1'b1); bit_in(1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("arst_cnt_c", 32'(cnt_c), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    check_eq("arst_match_a", 32'(cnt_a), 32'd1);
    check_eq("arst_match_b", 32'(cnt_b), 32'd1);

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      bit iv, b, pl, cc;
      iv = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom);
      pl = ($urandom_range(0, 79) == 0);
      cc = ($urandom_range(0, 149) == 0);
      if (pl) begin
        pat_in_a = 3'($urandom);
        pat_in_b = 3'($urandom);
        pat_in_c = 4'($urandom);
      end
      cycle(iv, b, pl, cc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_detect_param
